led_s2p_receiver: RTL and testbench
===================================

Name: led_s2p_receiver

Overview:
- Serial-to-parallel receiver; the counterpart of the team's 16-bit LED parallel-to-serial shifter.
- Captures an LSB-first serial frame: WIDTH data bits followed by one trailer bit that must be 0.
- Presents the captured word in parallel with a one-cycle valid pulse.
- Used on the loop-back/readback path and by benches to check what the P2S shifter emitted.

Parameters:
- WIDTH, 16: data bits per frame.
- TIMEOUT, 1023: max clk cycles allowed between consecutive s_en strobes inside a frame before the frame aborts.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle pulse; begins a new frame.
- s_en  input  1  bit strobe, one cycle per serial bit.
- s_in  input  1  serial data, sampled only when s_en=1.
- P_out  output  WIDTH  last good received word.
- valid  output  1  one-cycle pulse when P_out updates.
- frame_err  output  1  one-cycle pulse on bad trailer, timeout or aborted frame.
- busy  output  1  high while in SHIFT or TRAIL.
- frame_cnt  output  8  count of good frames; wraps 255 -> 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - P_out, shift register, bit counter, timeout counter and frame_cnt = 0.
  - valid, frame_err, busy = 0.
- States: IDLE, SHIFT, TRAIL.
- IDLE:
  - s_en and s_in are ignored.
  - start=1 -> SHIFT; bit counter and timeout counter cleared.
- SHIFT:
  - On s_en=1: sreg <= {s_in, sreg[WIDTH-1:1]}, bit counter +1, timeout counter cleared.
  - The first received bit ends in sreg[0] (LSB first).
  - When the WIDTH-th bit is taken -> TRAIL, on the same edge.
- TRAIL, on s_en=1:
  - s_in=0: P_out <= sreg, valid=1 on the next cycle, frame_cnt +1, -> IDLE.
  - s_in=1: frame_err=1, P_out and frame_cnt unchanged, -> IDLE.
- Timeout (SHIFT/TRAIL):
  - Timeout counter increments each cycle without s_en.
  - When it reaches TIMEOUT: frame_err=1, -> IDLE, P_out unchanged.
- busy = 1 exactly when state is SHIFT or TRAIL, decoded from state with no extra latency.
- Latency: valid asserts on the clk edge that samples the trailer; P_out is stable from that same edge.
- Simultaneous events:
  - start while busy: the current frame aborts with a frame_err pulse, and a new frame begins on the same edge (counters cleared, SHIFT).
  - start takes priority over s_en in the same cycle; that s_en bit is discarded.
  - start and trailer s_en in the same cycle: the abort wins; no valid pulse.
- valid and frame_err are never high together and never high for more than 1 cycle.
- Mid-operation rst=0: immediate IDLE, all outputs as reset; a partial frame is lost.
- Inputs are assumed synchronous to clk; no synchronizers inside.

Test Plan:
- Good frame: rst pulse, start, 16 strobes LSB first of 16'hA5C3, trailer 0 -> P_out=16'hA5C3, one valid pulse, frame_cnt=1, busy falls on the same edge.
- Bad trailer: frame 16'h1234 with trailer 1 -> frame_err pulse, P_out keeps previous value 16'hA5C3, frame_cnt unchanged.
- Timeout: start, 5 strobes, then idle 1023 cycles -> frame_err on cycle 1023, busy=0, next good frame 16'h00FF accepted normally.
- Restart: start, 8 strobes, start again, then full frame 16'hFFFF + trailer 0 -> one frame_err then one valid, P_out=16'hFFFF.
- Async reset: assert rst=0 between clk edges during SHIFT -> busy, P_out and frame_cnt go to 0 immediately without waiting for clk.
- Wrap: 256 good frames of 16'h0001 -> frame_cnt returns to 0, 256 valid pulses, no frame_err.

Source files
------------

// File: rtl/led_s2p_receiver.sv
// led_s2p_receiver: LSB-first serial-to-parallel receiver for the LED shifter
// loop-back path. A frame is WIDTH data bits followed by one trailer bit that
// must be 0. A good frame updates P_out with a one-cycle valid pulse. A bad
// trailer, an inter-strobe timeout, or a restart mid-frame gives a one-cycle
// frame_err pulse instead.
module led_s2p_receiver #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_en,
    input  logic             s_in,
    output logic [WIDTH-1:0] P_out,
    output logic             valid,
    output logic             frame_err,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_TRAIL = 2'd2;

    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    // The abort fires on the edge where the idle-cycle count would reach TIMEOUT.
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [BW-1:0]    bcnt_q,  bcnt_d;
    logic [TW-1:0]    tcnt_q,  tcnt_d;
    logic [WIDTH-1:0] pout_q,  pout_d;
    logic             valid_q, valid_d;
    logic             ferr_q,  ferr_d;
    logic [7:0]       fcnt_q,  fcnt_d;

    // Next-state logic: start beats s_en, s_en beats the timeout.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        pout_d  = pout_q;
        fcnt_d  = fcnt_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    bcnt_d  = '0;
                    tcnt_d  = '0;
                end
            end
            S_SHIFT, S_TRAIL: begin
                if (start) begin
                    // Restart: abort the current frame and begin a new one at once.
                    ferr_d  = 1'b1;
                    state_d = S_SHIFT;
                    bcnt_d  = '0;
                    tcnt_d  = '0;
                end else if (s_en) begin
                    tcnt_d = '0;
                    if (state_q == S_SHIFT) begin
                        sreg_d = {s_in, sreg_q[WIDTH-1:1]};
                        bcnt_d = bcnt_q + BW'(1);
                        if (bcnt_q == LAST_BIT) begin
                            state_d = S_TRAIL;
                        end
                    end else begin
                        if (!s_in) begin
                            pout_d  = sreg_q;
                            valid_d = 1'b1;
                            fcnt_d  = fcnt_q + 8'd1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign P_out     = pout_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign frame_cnt = fcnt_q;
    assign busy      = (state_q == S_SHIFT) || (state_q == S_TRAIL);

endmodule

// File: tb/tb_led_s2p_receiver.sv
// Bench for led_s2p_receiver: stimulus tasks push expected frame outcomes into
// a queue; a negedge monitor pops one entry per valid/frame_err pulse.
module tb_led_s2p_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        s_en = 1'b0;
    logic        s_in = 1'b0;
    logic [15:0] P_out;
    logic        valid, frame_err, busy;
    logic [7:0]  frame_cnt;

    led_s2p_receiver #(.WIDTH(16), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .start(start), .s_en(s_en), .s_in(s_in),
        .P_out(P_out), .valid(valid), .frame_err(frame_err),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [15:0] data;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          nvalid = 0;
    int          nerr = 0;
    logic [15:0] exp_p = '0;
    logic [7:0]  exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && (valid || frame_err)) begin
            if (valid) nvalid++;
            if (frame_err) nerr++;
            chk("valid_and_err_exclusive", {31'd0, valid & frame_err}, 32'd0);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b P_out=%0h", valid, frame_err, P_out);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
                chk("pulse_P_out", {16'd0, P_out}, {16'd0, e.data});
                chk("pulse_frame_cnt", {24'd0, frame_cnt}, {24'd0, e.cnt});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        s_en = 1'b1;
        s_in = b;
        tick();
        s_en = 1'b0;
        s_in = 1'b0;
    endtask

    task automatic start_pulse(input logic with_en);
        start = 1'b1;
        s_en  = with_en;
        s_in  = 1'b0;
        tick();
        start = 1'b0;
        s_en  = 1'b0;
    endtask

    task automatic push_good(input logic [15:0] d);
        exp_p = d;
        exp_cnt = exp_cnt + 8'd1;
        sbq.push_back('{is_err: 1'b0, data: exp_p, cnt: exp_cnt});
    endtask

    task automatic push_err();
        sbq.push_back('{is_err: 1'b1, data: exp_p, cnt: exp_cnt});
    endtask

    task automatic shift_word(input logic [15:0] d, input logic trailer);
        for (int i = 0; i < 16; i++) send_bit(d[i]);
        if (trailer) push_err();
        else push_good(d);
        send_bit(trailer);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v0, e0;
        // Reset state
        repeat (2) tick();
        chk("reset_P_out", {16'd0, P_out}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        rst = 1'b1;
        tick();

        // IDLE ignores strobes
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("idle_ignores_s_en_busy", {31'd0, busy}, 32'd0);

        // Good frame 16'hA5C3; busy drops on the trailer edge
        start_pulse(1'b0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 16; i++) send_bit(logic'(16'hA5C3 >> i));
        chk("busy_in_trail", {31'd0, busy}, 32'd1);
        push_good(16'hA5C3);
        send_bit(1'b0);
        chk("busy_falls_with_valid", {31'd0, busy}, 32'd0);
        chk("good_valid_now", {31'd0, valid}, 32'd1);
        chk("good_P_out", {16'd0, P_out}, 32'h0000A5C3);
        tick();
        chk("valid_one_cycle", {31'd0, valid}, 32'd0);

        // Bad trailer keeps P_out and frame_cnt
        start_pulse(1'b0);
        shift_word(16'h1234, 1'b1);
        chk("bad_busy", {31'd0, busy}, 32'd0);
        tick();

        // Timeout after 5 strobes: err on the 1023rd idle cycle
        start_pulse(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        push_err();
        n = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (frame_err) begin
                n = k;
                break;
            end
        end
        chk("timeout_cycle", n, 32'd1023);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        start_pulse(1'b0);
        shift_word(16'h00FF, 1'b0);
        tick();

        // Restart mid-frame, then a full 16'hFFFF frame
        start_pulse(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        push_err();
        start_pulse(1'b0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        shift_word(16'hFFFF, 1'b0);
        tick();

        // start together with the trailer strobe: abort wins, new frame begins;
        // the strobe in the start cycle is discarded
        start_pulse(1'b0);
        for (int i = 0; i < 16; i++) send_bit(1'b1);
        push_err();
        start_pulse(1'b1);
        shift_word(16'h5A5A, 1'b0);
        tick();

        // Asynchronous reset between edges during SHIFT
        start_pulse(1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_P_out", {16'd0, P_out}, 32'd0);
        chk("async_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        exp_p = '0;
        exp_cnt = '0;
        tick();
        rst = 1'b1;
        tick();

        // 256 good frames: frame_cnt wraps back to 0
        v0 = nvalid;
        e0 = nerr;
        for (int f = 0; f < 256; f++) begin
            start_pulse(1'b0);
            shift_word(16'h0001, 1'b0);
        end
        repeat (2) tick();
        chk("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("wrap_valid_pulses", nvalid - v0, 32'd256);
        chk("wrap_no_err", nerr - e0, 32'd0);
        chk("wrap_P_out", {16'd0, P_out}, 32'h00000001);

        repeat (3) tick();
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
